// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The producer/consumer side uses the master modport; the FIFO uses the slave modport.
interface sync_fifo_param_if #(
  parameter int DATA_W = 128,
  parameter int CW     = 5
);
  logic              i_flush;
  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic [DATA_W-1:0] o_rddata;
  logic              o_full;
  logic              o_empty;
  logic              o_alm_full;
  logic              o_alm_empty;
  logic [CW-1:0]     o_count;
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output i_flush, i_wren, i_wrdata, i_rden,
    input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty, o_count,
           o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_wren, i_wrdata, i_rden,
    output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty, o_count,
           o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, synchronous flush and registered status flags.
// Define FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int DATA_W       = 128,
  parameter int DEPTH        = 16,
  parameter int ALM_FULL_TH  = 14,
  parameter int ALM_EMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DATA_W < 1) begin : g_bad_width
      $error("sync_fifo_param: DATA_W must be >= 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two >= 4");
    end
    if (ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH - 1) begin : g_bad_afull
      $error("sync_fifo_param: ALM_FULL_TH out of range");
    end
    if (ALM_EMPTY_TH < 0 || ALM_EMPTY_TH > DEPTH - 2 || ALM_EMPTY_TH >= ALM_FULL_TH) begin : g_bad_aempty
      $error("sync_fifo_param: ALM_EMPTY_TH out of range");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              full_reg, empty_reg, alm_full_reg, alm_empty_reg;
  logic [DATA_W-1:0] rddata_reg;
  logic              rd_ok, wr_ok;

  assign rd_ok = bus.i_rden && !empty_reg;
  assign wr_ok = bus.i_wren && (!full_reg || rd_ok);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (bus.i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_next = rd_ptr_reg + 1'b1;
      if (wr_ok && !rd_ok)      count_next = count_reg + 1'b1;
      else if (rd_ok && !wr_ok) count_next = count_reg - 1'b1;
    end
  end

  // Flags come from the next count so they always agree with o_count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      alm_full_reg  <= 1'b0;
      alm_empty_reg <= 1'b1;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      full_reg      <= (count_next == CW'(DEPTH));
      empty_reg     <= (count_next == '0);
      alm_full_reg  <= (count_next >= CW'(ALM_FULL_TH));
      alm_empty_reg <= (count_next <= CW'(ALM_EMPTY_TH));
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.i_flush) mem[wr_ptr_reg] <= bus.i_wrdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       rddata_reg <= '0;
    else if (rd_ok && !bus.i_flush) rddata_reg <= mem[rd_ptr_reg];
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.i_wren && full_reg && !bus.i_rden) overflow_reg  <= 1'b1;
      if (bus.i_rden && empty_reg)               underflow_reg <= 1'b1;
    end
  end

  assign bus.o_overflow  = overflow_reg;
  assign bus.o_underflow = underflow_reg;
`else
  assign bus.o_overflow  = 1'b0;
  assign bus.o_underflow = 1'b0;
`endif

  assign bus.o_rddata    = rddata_reg;
  assign bus.o_full      = full_reg;
  assign bus.o_empty     = empty_reg;
  assign bus.o_alm_full  = alm_full_reg;
  assign bus.o_alm_empty = alm_empty_reg;
  assign bus.o_count     = count_reg;
endmodule
